// File: rtl/pri_icache_fetch_buffer.sv
// Single-line fetch buffer between the core instruction port and the private I-cache.
// Hits are served from the buffered line; misses fetch one full line from the cache.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | accept core requests, serve buffer hits, detect misses
// REQ     | line request presented to the cache, waiting for fetch_gnt_i
// WAIT    | line request accepted, waiting for fetch_rvalid_i
module pri_icache_fetch_buffer #(
    parameter int FETCH_ADDR_WIDTH = 32,
    parameter int FETCH_DATA_WIDTH = 128,
    parameter int INSTR_WIDTH      = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        instr_req_i,
    input  logic [FETCH_ADDR_WIDTH-1:0] instr_addr_i,
    output logic                        instr_gnt_o,
    output logic                        instr_rvalid_o,
    output logic [INSTR_WIDTH-1:0]      instr_rdata_o,
    output logic                        fetch_req_o,
    output logic [FETCH_ADDR_WIDTH-1:0] fetch_addr_o,
    input  logic                        fetch_gnt_i,
    input  logic                        fetch_rvalid_i,
    input  logic [FETCH_DATA_WIDTH-1:0] fetch_rdata_i,
    input  logic                        flush_i,
    output logic                        flush_ack_o
);

    localparam int OFF    = $clog2(FETCH_DATA_WIDTH / 8);
    localparam int WSEL_W = OFF - 2;
    localparam int TAG_W  = FETCH_ADDR_WIDTH - OFF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]                  r_state;
    logic                        r_buf_valid;
    logic [TAG_W-1:0]            r_buf_tag;
    logic [FETCH_DATA_WIDTH-1:0] r_buf_data;
    logic [FETCH_ADDR_WIDTH-1:0] r_fetch_addr;
    logic [WSEL_W-1:0]           r_wsel;
    logic                        r_kill;
    logic                        r_rvalid;
    logic [INSTR_WIDTH-1:0]      r_rdata;
    logic                        r_flush_ack;

    logic [TAG_W-1:0]            w_tag;
    logic [WSEL_W-1:0]           w_wsel;
    logic                        w_hit;
    logic [INSTR_WIDTH-1:0]      w_buf_word;
    logic [INSTR_WIDTH-1:0]      w_line_word;
    logic                        w_store;

    assign w_tag       = instr_addr_i[FETCH_ADDR_WIDTH-1:OFF];
    assign w_wsel      = instr_addr_i[OFF-1:2];
    assign w_hit       = r_buf_valid && (w_tag == r_buf_tag) && !flush_i;
    assign w_buf_word  = r_buf_data[w_wsel*INSTR_WIDTH +: INSTR_WIDTH];
    assign w_line_word = fetch_rdata_i[r_wsel*INSTR_WIDTH +: INSTR_WIDTH];

    // A flush seen at any point of the in-flight fetch (sticky or this cycle) drops the store.
    assign w_store = (r_state == ST_WAIT) && fetch_rvalid_i && !r_kill && !flush_i;

    assign instr_gnt_o    = (r_state == ST_IDLE) && instr_req_i;
    assign instr_rvalid_o = r_rvalid;
    assign instr_rdata_o  = r_rdata;
    assign fetch_req_o    = (r_state == ST_REQ);
    assign fetch_addr_o   = r_fetch_addr;
    assign flush_ack_o    = r_flush_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_buf_valid  <= 1'b0;
            r_buf_tag    <= '0;
            r_fetch_addr <= '0;
            r_wsel       <= '0;
            r_kill       <= 1'b0;
            r_rvalid     <= 1'b0;
            r_rdata      <= '0;
            r_flush_ack  <= 1'b0;
        end else begin
            r_rvalid    <= 1'b0;
            r_flush_ack <= flush_i;
            if (flush_i) begin
                r_buf_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    r_kill <= 1'b0;
                    if (instr_req_i) begin
                        if (w_hit) begin
                            r_rvalid <= 1'b1;
                            r_rdata  <= w_buf_word;
                        end else begin
                            r_fetch_addr <= {w_tag, {OFF{1'b0}}};
                            r_wsel       <= w_wsel;
                            r_state      <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (flush_i) begin
                        r_kill <= 1'b1;
                    end
                    if (fetch_gnt_i) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (flush_i) begin
                        r_kill <= 1'b1;
                    end
                    if (fetch_rvalid_i) begin
                        r_rvalid <= 1'b1;
                        r_rdata  <= w_line_word;
                        r_state  <= ST_IDLE;
                        if (w_store) begin
                            r_buf_valid <= 1'b1;
                            r_buf_tag   <= r_fetch_addr[FETCH_ADDR_WIDTH-1:OFF];
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Line storage carries no reset; r_buf_valid alone qualifies it.
    always_ff @(posedge clk) begin
        if (!rst && w_store) begin
            r_buf_data <= fetch_rdata_i;
        end
    end

endmodule

// File: tb/tb_pri_icache_fetch_buffer.sv
// Directed bench for pri_icache_fetch_buffer: hit/miss, gnt stall, flush, reset mid-fetch.
// Inputs change and outputs are sampled on the falling edge.
module tb_pri_icache_fetch_buffer;

    logic         clk;
    logic         rst;
    logic         instr_req_i;
    logic [31:0]  instr_addr_i;
    logic         instr_gnt_o;
    logic         instr_rvalid_o;
    logic [31:0]  instr_rdata_o;
    logic         fetch_req_o;
    logic [31:0]  fetch_addr_o;
    logic         fetch_gnt_i;
    logic         fetch_rvalid_i;
    logic [127:0] fetch_rdata_i;
    logic         flush_i;
    logic         flush_ack_o;

    int checks   = 0;
    int failures = 0;

    logic [127:0] line_a;
    logic [127:0] line_b;
    logic [127:0] line_c;
    logic [127:0] line_d;

    pri_icache_fetch_buffer #(
        .FETCH_ADDR_WIDTH(32),
        .FETCH_DATA_WIDTH(128),
        .INSTR_WIDTH(32)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .fetch_req_o    (fetch_req_o),
        .fetch_addr_o   (fetch_addr_o),
        .fetch_gnt_i    (fetch_gnt_i),
        .fetch_rvalid_i (fetch_rvalid_i),
        .fetch_rdata_i  (fetch_rdata_i),
        .flush_i        (flush_i),
        .flush_ack_o    (flush_ack_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Called at a falling edge with the DUT in REQ; serves one line and returns
    // at the falling edge where instr_rvalid_o should be visible.
    task automatic serve_miss(input logic [31:0] exp_addr, input logic [127:0] line,
                              input int gnt_delay, input bit flush_in_wait);
        for (int i = 0; i < gnt_delay; i++) begin
            chk("stall_req", fetch_req_o, 1'b1);
            chk("stall_addr", fetch_addr_o, exp_addr);
            chk("stall_gnt", instr_gnt_o, 1'b0);
            step();
        end
        fetch_gnt_i = 1'b1;
        #1;
        chk("req_valid", fetch_req_o, 1'b1);
        chk("req_addr", fetch_addr_o, exp_addr);
        step();
        fetch_gnt_i = 1'b0;
        chk("wait_noreq", fetch_req_o, 1'b0);
        if (flush_in_wait) begin
            flush_i = 1'b1;
            step();
            flush_i = 1'b0;
            chk("flush_ack_pulse", flush_ack_o, 1'b1);
        end
        fetch_rvalid_i = 1'b1;
        fetch_rdata_i  = line;
        step();
        fetch_rvalid_i = 1'b0;
        fetch_rdata_i  = '0;
        if (flush_in_wait) begin
            chk("flush_ack_once", flush_ack_o, 1'b0);
        end
    endtask

    initial begin
        line_a = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        line_b = {32'hB000_0013, 32'hB000_0012, 32'hB000_0011, 32'hB000_0010};
        line_c = {32'hC000_0203, 32'hC000_0202, 32'hC000_0201, 32'hC000_0200};
        line_d = {32'hD000_0303, 32'hD000_0302, 32'hD000_0301, 32'hD000_0300};

        rst            = 1'b1;
        instr_req_i    = 1'b0;
        instr_addr_i   = '0;
        fetch_gnt_i    = 1'b0;
        fetch_rvalid_i = 1'b0;
        fetch_rdata_i  = '0;
        flush_i        = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_gnt", instr_gnt_o, 1'b0);
        chk("rst_rvalid", instr_rvalid_o, 1'b0);
        chk("rst_rdata", instr_rdata_o, 32'h0);
        chk("rst_freq", fetch_req_o, 1'b0);
        chk("rst_faddr", fetch_addr_o, 32'h0);
        chk("rst_fack", flush_ack_o, 1'b0);

        // 1: cold miss at 0x100, one idle cycle before the cache grants
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h100;
        #1;
        chk("t1_gnt", instr_gnt_o, 1'b1);
        step();
        instr_req_i = 1'b0;
        chk("t1_no_rvalid", instr_rvalid_o, 1'b0);
        serve_miss(32'h100, line_a, 1, 1'b0);
        chk("t1_rvalid", instr_rvalid_o, 1'b1);
        chk("t1_rdata", instr_rdata_o, 32'hA000_0000);
        step();
        chk("t1_rvalid_pulse", instr_rvalid_o, 1'b0);

        // 2: back-to-back hits 0x104, 0x108, 0x10C
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h104;
        #1;
        chk("t2_gnt0", instr_gnt_o, 1'b1);
        step();
        chk("t2_rvalid1", instr_rvalid_o, 1'b1);
        chk("t2_rdata1", instr_rdata_o, 32'hA000_0001);
        chk("t2_noreq1", fetch_req_o, 1'b0);
        instr_addr_i = 32'h108;
        #1;
        chk("t2_gnt1", instr_gnt_o, 1'b1);
        step();
        chk("t2_rvalid2", instr_rvalid_o, 1'b1);
        chk("t2_rdata2", instr_rdata_o, 32'hA000_0002);
        chk("t2_noreq2", fetch_req_o, 1'b0);
        instr_addr_i = 32'h10C;
        #1;
        chk("t2_gnt2", instr_gnt_o, 1'b1);
        step();
        instr_req_i = 1'b0;
        chk("t2_rvalid3", instr_rvalid_o, 1'b1);
        chk("t2_rdata3", instr_rdata_o, 32'hA000_0003);
        chk("t2_noreq3", fetch_req_o, 1'b0);

        // 3: miss at 0x110 with the cache stalling the grant five cycles
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h110;
        #1;
        chk("t3_gnt", instr_gnt_o, 1'b1);
        step();
        instr_req_i = 1'b0;
        serve_miss(32'h110, line_b, 5, 1'b0);
        chk("t3_rvalid", instr_rvalid_o, 1'b1);
        chk("t3_rdata", instr_rdata_o, 32'hB000_0010);

        // 4: flush while waiting for 0x200; word delivered but line not kept
        step();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h200;
        #1;
        chk("t4_gnt", instr_gnt_o, 1'b1);
        step();
        instr_req_i = 1'b0;
        serve_miss(32'h200, line_c, 0, 1'b1);
        chk("t4_rvalid", instr_rvalid_o, 1'b1);
        chk("t4_rdata", instr_rdata_o, 32'hC000_0200);
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h204;
        #1;
        chk("t4_gnt2", instr_gnt_o, 1'b1);
        step();
        instr_req_i = 1'b0;
        chk("t4_refetch_req", fetch_req_o, 1'b1);
        chk("t4_refetch_addr", fetch_addr_o, 32'h200);
        chk("t4_no_hit", instr_rvalid_o, 1'b0);
        serve_miss(32'h200, line_c, 0, 1'b0);
        chk("t4_rdata2", instr_rdata_o, 32'hC000_0201);

        // 5: reset while waiting for 0x300, then the stale line arrives
        step();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h300;
        step();
        instr_req_i = 1'b0;
        fetch_gnt_i = 1'b1;
        step();
        fetch_gnt_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rst_faddr", fetch_addr_o, 32'h0);
        chk("t5_rst_freq", fetch_req_o, 1'b0);
        fetch_rvalid_i = 1'b1;
        fetch_rdata_i  = line_d;
        step();
        fetch_rvalid_i = 1'b0;
        fetch_rdata_i  = '0;
        chk("t5_ignored_rvalid", instr_rvalid_o, 1'b0);
        chk("t5_ignored_rdata", instr_rdata_o, 32'h0);
        chk("t5_freq", fetch_req_o, 1'b0);
        chk("t5_fack", flush_ack_o, 1'b0);
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h208;
        step();
        instr_req_i = 1'b0;
        chk("t5_buf_invalid_req", fetch_req_o, 1'b1);
        chk("t5_buf_invalid_addr", fetch_addr_o, 32'h200);
        chk("t5_buf_invalid_rv", instr_rvalid_o, 1'b0);
        serve_miss(32'h200, line_c, 0, 1'b0);
        chk("t5_rdata", instr_rdata_o, 32'hC000_0202);

        // 6: reload 0x100, then a request with flush_i high must miss
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h100;
        step();
        instr_req_i = 1'b0;
        serve_miss(32'h100, line_a, 0, 1'b0);
        chk("t6_load_rdata", instr_rdata_o, 32'hA000_0000);
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h10C;
        flush_i      = 1'b1;
        #1;
        chk("t6_gnt", instr_gnt_o, 1'b1);
        step();
        instr_req_i = 1'b0;
        flush_i     = 1'b0;
        chk("t6_fack", flush_ack_o, 1'b1);
        chk("t6_miss_req", fetch_req_o, 1'b1);
        chk("t6_miss_addr", fetch_addr_o, 32'h100);
        chk("t6_no_hit", instr_rvalid_o, 1'b0);
        serve_miss(32'h100, line_a, 0, 1'b0);
        chk("t6_rvalid", instr_rvalid_o, 1'b1);
        chk("t6_rdata", instr_rdata_o, 32'hA000_0003);
        // flush in IDLE must not poison the following fetch's store
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h108;
        step();
        instr_req_i = 1'b0;
        chk("t6_rehit_rvalid", instr_rvalid_o, 1'b1);
        chk("t6_rehit_rdata", instr_rdata_o, 32'hA000_0002);
        chk("t6_rehit_noreq", fetch_req_o, 1'b0);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
